// File: rtl/fifo_flex_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the flexible single-clock FIFO.
// No logic, so no latency.
// No flow control here; the FIFO reports full/empty and accepts or rejects each request.
package fifo_flex_pkg;

    // Read-side timing of the FIFO output.
    typedef enum logic {
        FIFO_STD  = 1'b0,   // registered read, data one cycle after the pop
        FIFO_FWFT = 1'b1    // head entry always presented on data_out
    } fifo_mode_t;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 64;

    // Map the integer FWFT parameter onto the mode enum.
    function automatic fifo_mode_t mode_of(input int fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
`timescale 1ns/1ps
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read port.
// Write visible to the read port on the cycle after the write edge; read is combinational.
// No backpressure; the caller only asserts we for accepted pushes.
module fifo_flex_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
`timescale 1ns/1ps
// Single-clock FIFO with standard or first-word-fall-through read, thresholds and sticky errors.
// STD: data_out valid the cycle after an accepted pop; FWFT: head entry visible whenever !empty.
// Pushes to a full FIFO are dropped (overflow), pops from an empty FIFO ignored (underflow).
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 60,
    parameter int AE_THRESH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [CNT_W-1:0]  FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_LVL    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]  AE_LVL    = CNT_W'(AE_THRESH);
    localparam fifo_mode_t        MODE      = mode_of(FWFT);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [CNT_W-1:0]  count_next;
    logic [WIDTH-1:0]  mem_rdata;

    // Accept decisions and next occupancy; a pop at full frees the slot the push needs.
    always_comb begin
        rd_acc     = rd_en & ~empty;
        wr_acc     = wr_en & (~full | rd_acc);
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    // Read/write pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Count and status flags registered from the next count so they never lag count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_next;
            full         <= (count_next == FULL_LVL);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_LVL);
            almost_empty <= (count_next <= AE_LVL);
        end
    end

    // Sticky errors: a fresh error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & ~wr_acc) | (overflow  & ~clr_err);
            underflow <= (rd_en & empty)   | (underflow & ~clr_err);
        end
    end

    fifo_flex_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (CLK),
        .we   (wr_acc & ~flush),
        .waddr(wr_ptr),
        .wdata(data_in),
        .raddr(rd_ptr),
        .rdata(mem_rdata)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head entry shown directly; forced to zero while empty so stale storage never leaks out.
        assign data_out = empty ? '0 : mem_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;

        // Registered read: capture the head on an accepted pop, otherwise hold.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                dout_q <= '0;
            end else if (flush) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem_rdata;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_flex.sv
`timescale 1ns/1ps
// Directed bench for fifo_flex: one STD and one FWFT instance driven by the same stimulus.
// Table rows give inputs for one clock and the expected state just after that edge.
// Multi-cycle corners (async reset, FWFT fall-through, wrap, flush) are hand-written sequences.
module tb_fifo_flex;

    logic       CLK = 1'b0;
    logic       RST;
    logic       flush, wr_en, rd_en, clr_err;
    logic [7:0] data_in;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] s_count, f_count;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_std (
        .CLK(CLK), .RST(RST), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf),
        .clr_err(clr_err));

    fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_fwft (
        .CLK(CLK), .RST(RST), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf),
        .clr_err(clr_err));

    always #5 CLK = ~CLK;

    // ctl = {flush, wr_en, rd_en, clr_err}; flg = {empty, full, almost_full, almost_empty, overflow, underflow}
    typedef struct {
        logic [3:0] ctl;
        logic [7:0] din;
        logic [2:0] cnt;
        logic [5:0] flg;
        logic [7:0] dstd;
        logic [7:0] dfw;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t v(input logic [3:0] ctl, input logic [7:0] din, input logic [2:0] cnt,
                               input logic [5:0] flg, input logic [7:0] dstd, input logic [7:0] dfw);
        vec_t r;
        r.ctl = ctl; r.din = din; r.cnt = cnt; r.flg = flg; r.dstd = dstd; r.dfw = dfw;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] cnt, input logic [5:0] flg,
                               input logic [7:0] dstd, input logic [7:0] dfw);
        chk({tag, " std count"}, 8'(s_count), 8'(cnt));
        chk({tag, " fwft count"}, 8'(f_count), 8'(cnt));
        chk({tag, " std flags"}, 8'({s_empty, s_full, s_af, s_ae, s_ovf, s_unf}), 8'(flg));
        chk({tag, " fwft flags"}, 8'({f_empty, f_full, f_af, f_ae, f_ovf, f_unf}), 8'(flg));
        chk({tag, " std data_out"}, s_dout, dstd);
        chk({tag, " fwft data_out"}, f_dout, dfw);
    endtask

    // Drive one cycle of inputs, clock it, and settle just after the edge.
    task automatic cyc(input logic [3:0] ctl, input logic [7:0] din);
        {flush, wr_en, rd_en, clr_err} = ctl;
        data_in = din;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] val;

        // Fill/drain with overflow, simultaneous at full, simultaneous at empty, clr_err races.
        tbl[0]  = v(4'b0100, 8'h11, 3'd1, 6'b000100, 8'h00, 8'h11);
        tbl[1]  = v(4'b0100, 8'h22, 3'd2, 6'b000000, 8'h00, 8'h11);
        tbl[2]  = v(4'b0100, 8'h33, 3'd3, 6'b001000, 8'h00, 8'h11);
        tbl[3]  = v(4'b0100, 8'h44, 3'd4, 6'b011000, 8'h00, 8'h11);
        tbl[4]  = v(4'b0100, 8'h55, 3'd4, 6'b011010, 8'h00, 8'h11);
        tbl[5]  = v(4'b0010, 8'h00, 3'd3, 6'b001010, 8'h11, 8'h22);
        tbl[6]  = v(4'b0010, 8'h00, 3'd2, 6'b000010, 8'h22, 8'h33);
        tbl[7]  = v(4'b0010, 8'h00, 3'd1, 6'b000110, 8'h33, 8'h44);
        tbl[8]  = v(4'b0010, 8'h00, 3'd0, 6'b100110, 8'h44, 8'h00);
        tbl[9]  = v(4'b0001, 8'h00, 3'd0, 6'b100100, 8'h44, 8'h00);
        tbl[10] = v(4'b0100, 8'h01, 3'd1, 6'b000100, 8'h44, 8'h01);
        tbl[11] = v(4'b0100, 8'h02, 3'd2, 6'b000000, 8'h44, 8'h01);
        tbl[12] = v(4'b0100, 8'h03, 3'd3, 6'b001000, 8'h44, 8'h01);
        tbl[13] = v(4'b0100, 8'h04, 3'd4, 6'b011000, 8'h44, 8'h01);
        tbl[14] = v(4'b0110, 8'h77, 3'd4, 6'b011000, 8'h01, 8'h02);
        tbl[15] = v(4'b0010, 8'h00, 3'd3, 6'b001000, 8'h02, 8'h03);
        tbl[16] = v(4'b0010, 8'h00, 3'd2, 6'b000000, 8'h03, 8'h04);
        tbl[17] = v(4'b0010, 8'h00, 3'd1, 6'b000100, 8'h04, 8'h77);
        tbl[18] = v(4'b0010, 8'h00, 3'd0, 6'b100100, 8'h77, 8'h00);
        tbl[19] = v(4'b0110, 8'h99, 3'd1, 6'b000101, 8'h77, 8'h99);
        tbl[20] = v(4'b0001, 8'h00, 3'd1, 6'b000100, 8'h77, 8'h99);
        tbl[21] = v(4'b0010, 8'h00, 3'd0, 6'b100100, 8'h99, 8'h00);
        tbl[22] = v(4'b0011, 8'h00, 3'd0, 6'b100101, 8'h99, 8'h00);
        tbl[23] = v(4'b0001, 8'h00, 3'd0, 6'b100100, 8'h99, 8'h00);

        // Power-on reset state.
        RST = 1'b1;
        {flush, wr_en, rd_en, clr_err} = 4'b0000;
        data_in = 8'h00;
        #12;
        check_state("reset", 3'd0, 6'b100100, 8'h00, 8'h00);
        @(negedge CLK);
        RST = 1'b0;

        // Asynchronous reset in the middle of traffic clears state without a clock edge.
        cyc(4'b0100, 8'hA1);
        cyc(4'b0100, 8'hA2);
        cyc(4'b0010, 8'h00);
        {flush, wr_en, rd_en, clr_err} = 4'b0000;
        check_state("pre-reset", 3'd1, 6'b000100, 8'hA1, 8'hA2);
        #2;
        RST = 1'b1;
        #1;
        check_state("mid reset", 3'd0, 6'b100100, 8'h00, 8'h00);
        #3;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].ctl, tbl[i].din);
            check_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].flg, tbl[i].dstd, tbl[i].dfw);
        end

        // FWFT fall-through: nothing shown before the write edge, head shown after without rd_en.
        {flush, wr_en, rd_en, clr_err} = 4'b0100;
        data_in = 8'h5A;
        #1;
        chk("fwft before write edge", f_dout, 8'h00);
        @(posedge CLK);
        #1;
        {flush, wr_en, rd_en, clr_err} = 4'b0000;
        check_state("fwft push", 3'd1, 6'b000100, 8'h99, 8'h5A);
        cyc(4'b0000, 8'h00);
        check_state("fwft hold", 3'd1, 6'b000100, 8'h99, 8'h5A);
        cyc(4'b0010, 8'h00);
        check_state("fwft pop", 3'd0, 6'b100100, 8'h5A, 8'h00);

        // Ten push/pop pairs walk both pointers around the ring more than twice.
        for (int i = 0; i < 10; i++) begin
            val = 8'h30 + 8'(i);
            cyc(4'b0100, val);
            chk($sformatf("wrap%0d fwft head", i), f_dout, val);
            cyc(4'b0010, 8'h00);
            chk($sformatf("wrap%0d std read", i), s_dout, val);
            chk($sformatf("wrap%0d count", i), 8'(s_count), 8'h00);
        end

        // Flush beats concurrent wr_en/rd_en and clears a pending underflow.
        cyc(4'b0010, 8'h00);
        check_state("underflow", 3'd0, 6'b100101, 8'h39, 8'h00);
        cyc(4'b0100, 8'hC1);
        cyc(4'b0100, 8'hC2);
        check_state("pre-flush", 3'd2, 6'b000001, 8'h39, 8'hC1);
        cyc(4'b1110, 8'hEE);
        check_state("flush", 3'd0, 6'b100100, 8'h00, 8'h00);
        cyc(4'b0000, 8'h00);
        check_state("post-flush idle", 3'd0, 6'b100100, 8'h00, 8'h00);
        cyc(4'b0100, 8'hD1);
        check_state("post-flush push", 3'd1, 6'b000100, 8'h00, 8'hD1);
        cyc(4'b0010, 8'h00);
        check_state("post-flush pop", 3'd0, 6'b100100, 8'hD1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
